// File: rtl/regbus_demux.sv
// regbus_demux: one-master to NUM_SLAVES-slave register-bus router.
// Requests are decoded against base/mask windows, with the lowest matching index
// winning. Each request goes to the selected slave, and the slave's response
// comes back to the master. Unmapped addresses and slave timeouts complete with
// ERR_DATA and the error flag set. A saturating counter records error responses.
module regbus_demux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_addr_valid,
  output logic                             m_reg_ready,
  input  logic                             m_reg_write,
  input  logic [ADDR_WIDTH-1:0]            m_reg_addr,
  input  logic [DATA_WIDTH-1:0]            m_reg_wdata,
  output logic [DATA_WIDTH-1:0]            m_reg_rdata,
  output logic                             m_reg_err,
  output logic [NUM_SLAVES-1:0]            s_addr_valid,
  input  logic [NUM_SLAVES-1:0]            s_reg_ready,
  output logic [NUM_SLAVES-1:0]            s_reg_write,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_reg_addr,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_reg_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_reg_rdata,
  output logic [ERR_CNT_W-1:0]             err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        sel, hit_idx;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic                    lat_write;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [TW-1:0]           tcnt;
  logic                    lat_ld, tcnt_clr, tcnt_inc, rsp_ld, rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // The counter holds at all-ones so that a long error burst cannot wrap it back to small values.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Address decode: scan downward so the lowest matching window is the one left selected.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_reg_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_ready = s_reg_ready[sel];
  assign sel_rdata = s_reg_rdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  // Every slave sees the latched request. Only the valid bit depends on the selected slave.
  assign s_reg_write = {NUM_SLAVES{lat_write}};
  assign s_reg_addr  = {NUM_SLAVES{lat_addr}};
  assign s_reg_wdata = {NUM_SLAVES{lat_wdata}};

  // Next-state logic, per-state control strobes and the master/slave handshake outputs.
  always_comb begin
    state_nxt    = state;
    lat_ld       = 1'b0;
    tcnt_clr     = 1'b0;
    tcnt_inc     = 1'b0;
    rsp_ld       = 1'b0;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    m_reg_ready  = 1'b0;
    s_addr_valid = '0;
    case (state)
      IDLE: begin
        if (m_addr_valid) begin
          lat_ld = 1'b1;
          if (hit) begin
            tcnt_clr  = 1'b1;
            state_nxt = FWD;
          end else begin
            rsp_ld    = 1'b1;
            rsp_err   = 1'b1;
            rsp_rdata = ERR_RDATA;
            state_nxt = RESP;
          end
        end
      end
      FWD: begin
        s_addr_valid[sel] = 1'b1;
        if (sel_ready) begin
          // A ready in the final timeout cycle is still taken as a good response.
          rsp_ld    = 1'b1;
          rsp_rdata = lat_write ? '0 : sel_rdata;
          state_nxt = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt == T_LAST)) begin
          rsp_ld    = 1'b1;
          rsp_err   = 1'b1;
          rsp_rdata = ERR_RDATA;
          state_nxt = RESP;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      RESP: begin
        m_reg_ready = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch, timeout counter, response holding registers and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      lat_addr    <= '0;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
      tcnt        <= '0;
      m_reg_rdata <= '0;
      m_reg_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      if (lat_ld) begin
        sel       <= hit_idx;
        lat_addr  <= m_reg_addr;
        lat_write <= m_reg_write;
        lat_wdata <= m_reg_wdata;
      end
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
      if (rsp_ld) begin
        m_reg_rdata <= rsp_rdata;
        m_reg_err   <= rsp_err;
      end
      if ((state == RESP) && m_reg_err) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_regbus_demux.sv
// Randomised scoreboard bench for regbus_demux. The bench plays both the master
// and the slave side. Slave 0's window covers 0x0000-0x1FFF, which shadows
// slave 1. Slaves 2 and 3 take 0x2000 and 0x3000. Timeout is 8 cycles and the
// error counter is 4 bits wide.
module tb_regbus_demux;

  localparam int AW = 32, DW = 32, NS = 4, TMO = 8, CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_addr_valid, m_reg_ready, m_reg_write, m_reg_err;
  logic [AW-1:0]     m_reg_addr;
  logic [DW-1:0]     m_reg_wdata, m_reg_rdata;
  logic [NS-1:0]     s_addr_valid, s_reg_ready, s_reg_write;
  logic [NS*AW-1:0]  s_reg_addr;
  logic [NS*DW-1:0]  s_reg_wdata, s_reg_rdata;
  logic [CW-1:0]     err_count;

  regbus_demux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SLAVE_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000}),
    .TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hDEAD_BEEF), .ERR_CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr_valid(m_addr_valid), .m_reg_ready(m_reg_ready), .m_reg_write(m_reg_write),
    .m_reg_addr(m_reg_addr), .m_reg_wdata(m_reg_wdata), .m_reg_rdata(m_reg_rdata),
    .m_reg_err(m_reg_err), .s_addr_valid(s_addr_valid), .s_reg_ready(s_reg_ready),
    .s_reg_write(s_reg_write), .s_reg_addr(s_reg_addr), .s_reg_wdata(s_reg_wdata),
    .s_reg_rdata(s_reg_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  bit          mon_en = 0, in_resp = 0;
  int          model_errs = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  // Plan shared with the slave responder for the current transaction.
  int          exp_sel = -1;
  logic [3:0]  exp_valid = '0;
  int          plan_d = 0;
  logic [31:0] plan_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic        exp_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference address map: plain address ranges, lowest slave index wins on overlap.
  function automatic int model_sel(input logic [31:0] a);
    if (a < 32'h2000) return 0;
    if (a < 32'h3000) return 2;
    if (a < 32'h4000) return 3;
    return -1;
  endfunction

  // Present one request and wait for its response. d is the number of slave-valid
  // cycles before the slave answers; any d above TMO means the slave never answers.
  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input int d, input logic [31:0] rd);
    exp_t e;
    int   s, tn;
    bit   got;
    s  = model_sel(a);
    tn = cyc + (in_resp ? 2 : 1);
    exp_sel    = s;
    exp_valid  = (s < 0) ? 4'b0 : 4'(1 << s);
    plan_d     = d;
    plan_rdata = rd;
    exp_addr   = a;
    exp_wdata  = wd;
    exp_wr     = wr;
    if (s < 0) begin
      e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.cyc = tn;
    end else if (d > TMO) begin
      e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.cyc = tn + TMO;
    end else begin
      e.rdata = wr ? 32'h0 : rd; e.err = 1'b0; e.cyc = tn + d;
    end
    if (e.err) model_errs++;
    e.cnt = (model_errs > 15) ? 4'hF : 4'(model_errs);
    sb.push_back(e);
    m_addr_valid = 1'b1;
    m_reg_write  = wr;
    m_reg_addr   = a;
    m_reg_wdata  = wd;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_reg_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL response_wait: no m_reg_ready within 40 cycles for addr 0x%0h", a);
    end
    in_resp = 1;
  endtask

  task automatic gap(input int n);
    m_addr_valid = 1'b0;
    if (n > 0) begin
      repeat (n) @(negedge clk);
      in_resp = 0;
    end
  endtask

  // Slave responder: checks forwarded fields on the first valid cycle and answers after plan_d
  // cycles. It drives random noise on every ready bit the router must ignore.
  initial begin
    int vcnt;
    logic [3:0] rdy;
    vcnt = 0;
    s_reg_ready = '0;
    s_reg_rdata = '0;
    forever begin
      @(negedge clk);
      s_reg_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (!mon_en) begin
        vcnt = 0;
        s_reg_ready = '0;
      end else if (s_addr_valid == '0) begin
        vcnt = 0;
        s_reg_ready = 4'($urandom);
      end else begin
        vcnt++;
        if (vcnt == 1) begin
          chk("s_addr_valid", 64'(s_addr_valid), 64'(exp_valid));
          if (exp_sel >= 0) begin
            chk("s_reg_addr", 64'(s_reg_addr[exp_sel*32 +: 32]), 64'(exp_addr));
            chk("s_reg_write", 64'(s_reg_write[exp_sel]), 64'(exp_wr));
            chk("s_reg_wdata", 64'(s_reg_wdata[exp_sel*32 +: 32]), 64'(exp_wdata));
          end
        end
        rdy = 4'($urandom) & ~s_addr_valid;
        if (vcnt == plan_d) begin
          rdy = rdy | s_addr_valid;
          if (exp_sel >= 0) s_reg_rdata[exp_sel*32 +: 32] = plan_rdata;
        end
        s_reg_ready = rdy;
      end
    end
  end

  // Monitor: pops the scoreboard on every response and checks held outputs between responses.
  initial begin
    exp_t e;
    bit   cnt_pend;
    logic [3:0] cnt_exp;
    cnt_pend = 0;
    cnt_exp  = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (cnt_pend) begin
        chk("err_count", 64'(err_count), 64'(cnt_exp));
        cnt_pend = 0;
      end
      if (m_reg_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_ready: got m_reg_ready=1 required no response (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("m_reg_rdata", 64'(m_reg_rdata), 64'(e.rdata));
          chk("m_reg_err", 64'(m_reg_err), 64'(e.err));
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
          last_rdata = e.rdata;
          last_err   = e.err;
          cnt_pend   = 1;
          cnt_exp    = e.cnt;
        end
      end else begin
        chk("rdata_hold", 64'(m_reg_rdata), 64'(last_rdata));
        chk("err_hold", 64'(m_reg_err), 64'(last_err));
      end
    end
  end

  // Master: directed cases, a randomised run, reset mid-transaction and error saturation.
  initial begin
    logic [31:0] a;
    int r;
    rst = 1'b1;
    m_addr_valid = 1'b0; m_reg_write = 1'b0; m_reg_addr = '0; m_reg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_reg_ready", 64'(m_reg_ready), 64'd0);
    chk("rst_m_reg_rdata", 64'(m_reg_rdata), 64'd0);
    chk("rst_m_reg_err", 64'(m_reg_err), 64'd0);
    chk("rst_s_addr_valid", 64'(s_addr_valid), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    issue(32'h2010, 1'b0, 32'h0, 3, 32'h1234_5678);       gap(1);
    issue(32'h0004, 1'b1, 32'hA5A5_A5A5, 1, 32'h5555_0000); gap(2);
    issue(32'h8000, 1'b0, 32'h0, 1, 32'h0);               gap(1);
    issue(32'h3008, 1'b0, 32'h0, 99, 32'h0);              gap(4);
    issue(32'h3000, 1'b0, 32'h0, TMO, 32'hCAFE_F00D);     gap(1);
    issue(32'h1000, 1'b0, 32'h0, 2, 32'h0101_0101);
    issue(32'h2FFC, 1'b1, 32'h7777_8888, 1, 32'h0);
    issue(32'h1FFC, 1'b0, 32'h0, 4, 32'h9ABC_DEF0);
    issue(32'h4000, 1'b0, 32'h0, 1, 32'h0);               gap(1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 3);
      a = (r < 3) ? 32'($urandom_range(0, 32'h3FFF)) : 32'($urandom_range(32'h4000, 32'hFFFF_FFFF));
      issue(a, 1'($urandom), $urandom, $urandom_range(1, TMO + 2), $urandom);
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end
    gap(4);

    // Reset while the router is waiting on slave 3: the request is dropped without a response.
    exp_sel = 3; exp_valid = 4'b1000; plan_d = 99; exp_addr = 32'h3abc;
    exp_wr = 1'b0; exp_wdata = 32'h0;
    m_addr_valid = 1'b1; m_reg_write = 1'b0; m_reg_addr = 32'h3abc; m_reg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_addr_valid = 1'b0;
    sb.delete();
    model_errs = 0;
    last_rdata = '0;
    last_err   = 1'b0;
    @(negedge clk);
    chk("midrst_s_addr_valid", 64'(s_addr_valid), 64'd0);
    chk("midrst_m_reg_ready", 64'(m_reg_ready), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    in_resp = 0;
    @(negedge clk);
    issue(32'h2000, 1'b0, 32'h0, 2, 32'h600D_600D);       gap(1);

    for (int n = 0; n < 20; n++) begin
      issue(32'h0001_0000 + 32'(n), 1'b0, 32'h0, 1, 32'h0);
      if (n % 2 == 1) gap(1);
    end
    gap(5);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end, got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
